i2c_reg_target: RTL and testbench



---
 rtl/i2c_pkg.sv | 23 ++
 rtl/i2c_line_sync.sv | 48 ++++
 rtl/i2c_reg_target.sv | 201 ++++++++++++++++++++
 tb/tb_i2c_reg_target.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the oversampled I2C register target.
package i2c_pkg;

  localparam int BYTE_W = 8;

  // Level on SDA during the acknowledge slot
  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RACK,
    ST_IGNORE
  } state_t;

endpackage

// File: rtl/i2c_line_sync.sv
// Brings SCL/SDA into the clk domain and derives single-cycle bus events:
// SCL rising/falling edges plus START and STOP conditions.
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_d;
  logic                   sda_d;
  logic                   scl_s;

  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];

  // Synchroniser chains plus one delayed copy for edge detection; reset to
  // the idle-bus level so leaving reset never fakes an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  assign scl_rise  =  scl_s & ~scl_d;
  assign scl_fall  = ~scl_s &  scl_d;
  // SDA may only move while SCL is held high for START/STOP to count
  assign start_det = scl_s & scl_d &  sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d &  sda_s;

endmodule

// File: rtl/i2c_reg_target.sv
// I2C target oversampled by clk: 7-bit address match, pointer byte, then
// byte writes or reads of a small register file with pointer auto-increment.
//
// state        | meaning
// -------------+-------------------------------------------------------
// ST_IDLE      | bus free or after STOP, SDA released
// ST_ADDR      | shifting address + R/W byte
// ST_ADDR_ACK  | driving ACK for a matched address
// ST_PTR       | shifting register pointer byte
// ST_PTR_ACK   | driving ACK for an in-range pointer
// ST_WDATA     | shifting write data byte
// ST_WDATA_ACK | driving ACK after a register write
// ST_RDATA     | driving read data bits MSB first
// ST_RACK      | SDA released, sampling controller ACK/NACK
// ST_IGNORE    | not addressed or refused, wait for START/STOP
module i2c_reg_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADDR        = 7'h08,
  parameter int         NUM_REGS    = 4,
  parameter int         SYNC_STAGES = 2,
  localparam int        IDX_W       = $clog2(NUM_REGS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       scl_i,
  input  logic                       sda_i,
  output logic                       sda_oe,
  output logic [NUM_REGS*BYTE_W-1:0] reg_q,
  output logic                       wr_stb,
  output logic [IDX_W-1:0]           wr_idx,
  output logic                       busy
);

  logic              sda_s;
  logic              scl_rise;
  logic              scl_fall;
  logic              start_det;
  logic              stop_det;

  state_t            state;
  logic [2:0]        bit_cnt;
  logic              byte_done;
  logic [BYTE_W-1:0] shreg;
  logic [BYTE_W-1:0] rbuf;
  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  ptr_nxt;
  logic              mack;
  logic              ptr_ok;
  logic [BYTE_W-1:0] regs [NUM_REGS];

  i2c_line_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_line_sync (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .sda_s     (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  assign ptr_nxt = (ptr == IDX_W'(NUM_REGS - 1)) ? '0 : ptr + IDX_W'(1);
  assign ptr_ok  = ({1'b0, shreg} < 9'(NUM_REGS));

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
    assign reg_q[k*BYTE_W +: BYTE_W] = regs[k];
  end

  // Protocol FSM: bits are sampled on SCL rise, SDA is only changed on SCL
  // fall, and byte decisions are taken on the fall that ends bit 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      byte_done <= 1'b0;
      shreg     <= '0;
      rbuf      <= '0;
      ptr       <= '0;
      mack      <= I2C_NACK;
      sda_oe    <= 1'b0;
      wr_stb    <= 1'b0;
      wr_idx    <= '0;
      busy      <= 1'b0;
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
    end else begin
      wr_stb <= 1'b0;
      if (start_det) begin
        state     <= ST_ADDR;
        bit_cnt   <= '0;
        byte_done <= 1'b0;
        sda_oe    <= 1'b0;
        busy      <= 1'b1;
      end else if (stop_det) begin
        state     <= ST_IDLE;
        bit_cnt   <= '0;
        byte_done <= 1'b0;
        sda_oe    <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          ST_ADDR, ST_PTR, ST_WDATA: begin
            if (scl_rise) begin
              shreg     <= {shreg[BYTE_W-2:0], sda_s};
              bit_cnt   <= bit_cnt + 3'd1;
              byte_done <= (bit_cnt == 3'd7);
            end else if (scl_fall && byte_done) begin
              byte_done <= 1'b0;
              if (state == ST_ADDR) begin
                if (shreg[7:1] == ADDR) begin
                  state  <= ST_ADDR_ACK;
                  sda_oe <= 1'b1;
                end else begin
                  state <= ST_IGNORE;
                  busy  <= 1'b0;
                end
              end else if (state == ST_PTR) begin
                if (ptr_ok) begin
                  ptr    <= shreg[IDX_W-1:0];
                  state  <= ST_PTR_ACK;
                  sda_oe <= 1'b1;
                end else begin
                  state <= ST_IGNORE;
                  busy  <= 1'b0;
                end
              end else begin
                regs[ptr] <= shreg;
                wr_stb    <= 1'b1;
                wr_idx    <= ptr;
                ptr       <= ptr_nxt;
                state     <= ST_WDATA_ACK;
                sda_oe    <= 1'b1;
              end
            end
          end
          ST_ADDR_ACK: begin
            if (scl_fall) begin
              bit_cnt <= '0;
              if (shreg[0]) begin
                // Latch the whole byte now so a concurrent write cannot tear it
                rbuf   <= regs[ptr];
                sda_oe <= ~regs[ptr][BYTE_W-1];
                state  <= ST_RDATA;
              end else begin
                sda_oe <= 1'b0;
                state  <= ST_PTR;
              end
            end
          end
          ST_PTR_ACK, ST_WDATA_ACK: begin
            if (scl_fall) begin
              bit_cnt <= '0;
              sda_oe  <= 1'b0;
              state   <= ST_WDATA;
            end
          end
          ST_RDATA: begin
            if (scl_rise) begin
              bit_cnt   <= bit_cnt + 3'd1;
              byte_done <= (bit_cnt == 3'd7);
            end else if (scl_fall) begin
              if (byte_done) begin
                byte_done <= 1'b0;
                sda_oe    <= 1'b0;
                state     <= ST_RACK;
              end else begin
                rbuf   <= {rbuf[BYTE_W-2:0], 1'b0};
                sda_oe <= ~rbuf[BYTE_W-2];
              end
            end
          end
          ST_RACK: begin
            if (scl_rise) begin
              // Every transmitted byte advances the pointer, ACKed or not
              mack <= sda_s;
              ptr  <= ptr_nxt;
            end else if (scl_fall) begin
              bit_cnt <= '0;
              if (mack == I2C_ACK) begin
                rbuf   <= regs[ptr];
                sda_oe <= ~regs[ptr][BYTE_W-1];
                state  <= ST_RDATA;
              end else begin
                sda_oe <= 1'b0;
                busy   <= 1'b0;
                state  <= ST_IGNORE;
              end
            end
          end
          default: begin
            sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_reg_target.sv
// Directed bench for i2c_reg_target: a bit-banged controller drives the bus,
// expected register writes are queued and checked by a wr_stb monitor.
module tb_i2c_reg_target;

  localparam int NREGS = 4;
  localparam int Q     = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m_scl = 1'b1;
  logic        m_sda = 1'b1;
  logic        scl_i;
  logic        sda_i;
  logic        sda_oe;
  logic [31:0] reg_q;
  logic        wr_stb;
  logic [1:0]  wr_idx;
  logic        busy;

  typedef struct {
    int         idx;
    logic [7:0] data;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  logic [31:0] model = '0;
  logic        oe_seen = 1'b0;
  int          tests = 0;
  int          fails = 0;

  assign scl_i = m_scl;
  assign sda_i = m_sda & ~sda_oe;

  i2c_reg_target #(
    .ADDR        (7'h08),
    .NUM_REGS    (NREGS),
    .SYNC_STAGES (2)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .scl_i  (scl_i),
    .sda_i  (sda_i),
    .sda_oe (sda_oe),
    .reg_q  (reg_q),
    .wr_stb (wr_stb),
    .wr_idx (wr_idx),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest queued expectation
  always @(negedge clk) begin
    if (sda_oe) oe_seen = 1'b1;
    if (!rst && wr_stb) begin
      if (exp_q.size() == 0) begin
        chk("unexpected wr_stb", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_idx", 32'(wr_idx), 32'(mon_e.idx));
        chk("wr_data", 32'(reg_q[mon_e.idx*8 +: 8]), 32'(mon_e.data));
      end
    end
  end

  task automatic push_wr(input int idx, input logic [7:0] d);
    wr_t e;
    e.idx  = idx;
    e.data = d;
    exp_q.push_back(e);
    model[idx*8 +: 8] = d;
  endtask

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; wait_q();
    m_scl = 1'b1; wait_q();
    m_sda = 1'b0; wait_q();
    m_scl = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; wait_q();
    m_scl = 1'b1; wait_q();
    m_sda = 1'b1; wait_q();
  endtask

  task automatic i2c_bit(input logic b, output logic s);
    m_sda = b;    wait_q();
    m_scl = 1'b1; wait_q();
    s = sda_i;    wait_q();
    m_scl = 1'b0; wait_q();
  endtask

  task automatic wbyte(input string name, input logic [7:0] d, input logic exp_ack);
    logic s;
    for (int i = 7; i >= 0; i--) i2c_bit(d[i], s);
    i2c_bit(1'b1, s);
    chk(name, 32'(s), 32'(exp_ack));
  endtask

  task automatic rbyte(input string name, input logic nack, input logic [7:0] exp_d);
    logic       s;
    logic [7:0] d;
    d = '0;
    for (int i = 7; i >= 0; i--) begin
      i2c_bit(1'b1, s);
      d[i] = s;
    end
    i2c_bit(nack, s);
    chk(name, 32'(d), 32'(exp_d));
  endtask

  initial begin
    logic s;
    repeat (3) @(negedge clk);
    chk("reset sda_oe", 32'(sda_oe), 32'd0);
    chk("reset wr_stb", 32'(wr_stb), 32'd0);
    chk("reset wr_idx", 32'(wr_idx), 32'd0);
    chk("reset busy",   32'(busy),   32'd0);
    chk("reset reg_q",  reg_q,       32'd0);
    rst = 1'b0;
    wait_q();

    // single write: ptr 1 <- 0x67
    i2c_start();
    wbyte("wr addr ack", 8'h10, 1'b0);
    chk("wr busy", 32'(busy), 32'd1);
    wbyte("wr ptr ack", 8'h01, 1'b0);
    push_wr(1, 8'h67);
    wbyte("wr data ack", 8'h67, 1'b0);
    i2c_stop();
    chk("wr busy after stop", 32'(busy), 32'd0);
    chk("wr reg_q", reg_q, model);

    // burst write wrapping 3 -> 0
    i2c_start();
    wbyte("burst addr ack", 8'h10, 1'b0);
    wbyte("burst ptr ack", 8'h03, 1'b0);
    push_wr(3, 8'h11);
    wbyte("burst d0 ack", 8'h11, 1'b0);
    push_wr(0, 8'h22);
    wbyte("burst d1 ack", 8'h22, 1'b0);
    i2c_stop();
    chk("burst reg_q", reg_q, 32'h1100_6722);

    // pointer write, repeated START, two-byte read
    i2c_start();
    wbyte("rd addr ack", 8'h10, 1'b0);
    wbyte("rd ptr ack", 8'h01, 1'b0);
    i2c_start();
    wbyte("rd addr+r ack", 8'h11, 1'b0);
    rbyte("rd byte0", 1'b0, 8'h67);
    rbyte("rd byte1", 1'b1, model[23:16]);
    chk("rd sda released", 32'(sda_oe), 32'd0);
    chk("rd busy after nack", 32'(busy), 32'd0);
    i2c_stop();
    // pointer should now sit at 3
    i2c_start();
    wbyte("rd2 addr+r ack", 8'h11, 1'b0);
    rbyte("rd2 ptr persisted", 1'b1, 8'h11);
    i2c_stop();

    // address mismatch
    oe_seen = 1'b0;
    i2c_start();
    wbyte("miss addr nack", 8'h12, 1'b1);
    chk("miss busy", 32'(busy), 32'd0);
    wbyte("miss data nack", 8'hAA, 1'b1);
    i2c_stop();
    chk("miss sda_oe never", 32'(oe_seen), 32'd0);
    chk("miss reg_q", reg_q, model);

    // out-of-range pointer
    i2c_start();
    wbyte("badptr addr ack", 8'h10, 1'b0);
    wbyte("badptr ptr nack", 8'h07, 1'b1);
    wbyte("badptr data nack", 8'h55, 1'b1);
    i2c_stop();
    chk("badptr reg_q", reg_q, model);

    // reset in the middle of a data byte
    i2c_start();
    wbyte("rst addr ack", 8'h10, 1'b0);
    wbyte("rst ptr ack", 8'h00, 1'b0);
    i2c_bit(1'b0, s);
    i2c_bit(1'b1, s);
    i2c_bit(1'b0, s);
    i2c_bit(1'b1, s);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst sda_oe", 32'(sda_oe), 32'd0);
    chk("midrst reg_q", reg_q, 32'd0);
    chk("midrst busy", 32'(busy), 32'd0);
    rst = 1'b0;
    model = '0;
    i2c_stop();
    i2c_start();
    wbyte("post addr ack", 8'h10, 1'b0);
    wbyte("post ptr ack", 8'h00, 1'b0);
    push_wr(0, 8'h5A);
    wbyte("post data ack", 8'h5A, 1'b0);
    i2c_stop();
    chk("post reg_q", reg_q, 32'h0000_005A);

    chk("write queue drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
